// File: rtl/overflow_event_logger_pkg.sv
// Shared definitions for the overflow event logger and related stream blocks.
//   - evt_kind_e : record kind encoding carried on evt_kind
//   - rec_w()    : packed record width {kind, count, timestamp}
package overflow_event_logger_pkg;

  localparam int unsigned KIND_W = 2;

  typedef enum logic [KIND_W-1:0] {
    EVT_OVERFLOW = 2'd0,
    EVT_EN_RISE  = 2'd1,
    EVT_EN_FALL  = 2'd2,
    EVT_RSVD     = 2'd3
  } evt_kind_e;

  // Width of one packed event record.
  function automatic int unsigned rec_w(input int unsigned count_w, input int unsigned ts_w);
    return KIND_W + count_w + ts_w;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO.
// Ports:
//   clk, rst         : clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_wdata  : write request and data; ignored when full unless popping
//   i_pop            : consume head; ignored when empty
//   o_rdata          : current head (valid while !o_empty)
//   o_empty, o_full  : occupancy flags
//   o_level          : occupied entries, 0..DEPTH
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;

  logic w_do_pop;
  logic w_do_push;

  assign o_empty   = (r_level == '0);
  assign o_full    = (r_level == LW'(DEPTH));
  assign o_level   = r_level;
  assign o_rdata   = r_mem[r_rd_ptr];

  // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Storage carries no reset; occupancy is tracked by r_level alone.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/overflow_event_logger.sv
// Logs overflow rising edges and enable rise/fall transitions of a counter.
// Each event is stamped with a free-running timestamp and a count snapshot
// and queued in an FWFT FIFO drained over a valid/ready stream.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   count_in       : counter value snapshot source
//   overflow_in    : counter overflow flag
//   enable_in      : counter enable
//   evt_valid      : head record present
//   evt_ready      : consumer accepts head
//   evt_kind       : 0=OVERFLOW, 1=EN_RISE, 2=EN_FALL
//   evt_count      : count_in at the event cycle
//   evt_timestamp  : timestamp at the event cycle
//   drop_count     : saturating count of lost events
//   fifo_level     : occupied FIFO entries
module overflow_event_logger
  import overflow_event_logger_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 8,
  parameter int unsigned TS_WIDTH    = 16,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [COUNT_WIDTH-1:0]     count_in,
  input  logic                       overflow_in,
  input  logic                       enable_in,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [1:0]                 evt_kind,
  output logic [COUNT_WIDTH-1:0]     evt_count,
  output logic [TS_WIDTH-1:0]        evt_timestamp,
  output logic [7:0]                 drop_count,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int unsigned REC_W = rec_w(COUNT_WIDTH, TS_WIDTH);

  logic [TS_WIDTH-1:0] r_ts;
  logic                r_ovf_q;
  logic                r_en_q;
  logic [7:0]          r_drop;

  logic                w_ovf_rise;
  logic                w_en_rise;
  logic                w_en_fall;
  logic [1:0]          w_n_evt;
  logic                w_any_evt;
  evt_kind_e           w_kind;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic                w_push_ok;
  logic [1:0]          w_loss;
  logic [8:0]          w_drop_sum;
  logic [REC_W-1:0]    w_wrec;
  logic [REC_W-1:0]    w_head;

  assign w_ovf_rise = overflow_in & ~r_ovf_q;
  assign w_en_rise  = enable_in & ~r_en_q;
  assign w_en_fall  = ~enable_in & r_en_q;

  // en_rise and en_fall are exclusive, so at most two events per cycle.
  assign w_n_evt    = 2'(w_ovf_rise) + 2'(w_en_rise) + 2'(w_en_fall);
  assign w_any_evt  = (w_n_evt != 2'd0);

  // Priority select: OVERFLOW > EN_RISE > EN_FALL.
  always_comb begin
    w_kind = EVT_OVERFLOW;
    if (w_ovf_rise)     w_kind = EVT_OVERFLOW;
    else if (w_en_rise) w_kind = EVT_EN_RISE;
    else if (w_en_fall) w_kind = EVT_EN_FALL;
  end

  assign evt_valid  = ~w_empty;
  assign w_pop      = evt_valid & evt_ready;
  assign w_push_ok  = w_any_evt & (~w_full | w_pop);

  // Losses: lower-priority collisions plus a rejected push.
  assign w_loss     = (w_any_evt ? (w_n_evt - 2'd1) : 2'd0) + 2'(w_any_evt & ~w_push_ok);
  assign w_drop_sum = 9'(r_drop) + 9'(w_loss);

  assign w_wrec     = {w_kind, count_in, r_ts};

  // Edge registers reload from the live inputs in reset so release is event-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ts    <= '0;
      r_ovf_q <= overflow_in;
      r_en_q  <= enable_in;
      r_drop  <= '0;
    end else begin
      r_ts    <= r_ts + TS_WIDTH'(1);
      r_ovf_q <= overflow_in;
      r_en_q  <= enable_in;
      r_drop  <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  sync_fifo_fwft #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push_ok),
    .i_wdata (w_wrec),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_level (fifo_level)
  );

  // Head fields read as zero while the queue is empty.
  assign {evt_kind, evt_count, evt_timestamp} = evt_valid ? w_head : '0;
  assign drop_count = r_drop;

endmodule

// File: tb/tb_overflow_event_logger.sv
module tb_overflow_event_logger;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  count_in;
  logic        overflow_in;
  logic        enable_in;
  logic        evt_ready;

  logic        evt_valid;
  logic [1:0]  evt_kind;
  logic [7:0]  evt_count;
  logic [15:0] evt_timestamp;
  logic [7:0]  drop_count;
  logic [2:0]  fifo_level;

  logic        s_valid;
  logic [1:0]  s_kind;
  logic [7:0]  s_count;
  logic [3:0]  s_timestamp;
  logic [7:0]  s_drop;
  logic [2:0]  s_level;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  overflow_event_logger #(.COUNT_WIDTH(8), .TS_WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .count_in(count_in), .overflow_in(overflow_in),
    .enable_in(enable_in), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_kind(evt_kind), .evt_count(evt_count), .evt_timestamp(evt_timestamp),
    .drop_count(drop_count), .fifo_level(fifo_level)
  );

  // Narrow-timestamp instance for wrap behaviour; shares all stimulus.
  overflow_event_logger #(.COUNT_WIDTH(8), .TS_WIDTH(4), .DEPTH(4)) dut_s (
    .clk(clk), .rst(rst), .count_in(count_in), .overflow_in(overflow_in),
    .enable_in(enable_in), .evt_valid(s_valid), .evt_ready(evt_ready),
    .evt_kind(s_kind), .evt_count(s_count), .evt_timestamp(s_timestamp),
    .drop_count(s_drop), .fifo_level(s_level)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves rst low in the first post-reset cycle (timestamp 0).
  task automatic do_reset(input logic ovf, input logic en);
    rst = 1'b1;
    overflow_in = ovf;
    enable_in = en;
    repeat (10) tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; count_in = 8'h00; overflow_in = 1'b0; enable_in = 1'b0; evt_ready = 1'b0;

    // Inputs high through reset release: no record.
    do_reset(1'b1, 1'b1);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_kind", 32'(evt_kind), 32'd0);
    check("rst_count", 32'(evt_count), 32'd0);
    check("rst_ts", 32'(evt_timestamp), 32'd0);
    repeat (3) tick();
    check("rel_valid", 32'(evt_valid), 32'd0);
    check("rel_level", 32'(fifo_level), 32'd0);
    check("rel_drop", 32'(drop_count), 32'd0);

    // Enable rise at ts=20.
    do_reset(1'b0, 1'b0);
    evt_ready = 1'b1;
    repeat (20) tick();
    enable_in = 1'b1;
    tick();
    check("enr_valid", 32'(evt_valid), 32'd1);
    check("enr_kind", 32'(evt_kind), 32'd1);
    check("enr_ts", 32'(evt_timestamp), 32'd20);
    check("enr_level", 32'(fifo_level), 32'd1);
    tick();
    check("enr_popped", 32'(evt_valid), 32'd0);

    // Overflow and enable rise together.
    do_reset(1'b0, 1'b0);
    count_in = 8'hA5; overflow_in = 1'b1; enable_in = 1'b1;
    tick();
    check("col_valid", 32'(evt_valid), 32'd1);
    check("col_kind", 32'(evt_kind), 32'd0);
    check("col_count", 32'(evt_count), 32'hA5);
    check("col_ts", 32'(evt_timestamp), 32'd0);
    check("col_drop", 32'(drop_count), 32'd1);
    tick();
    check("col_popped", 32'(evt_valid), 32'd0);

    // Six events into a stalled 4-deep FIFO.
    do_reset(1'b0, 1'b0);
    evt_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      enable_in = (i % 2 == 0);
      count_in = 8'(8'h10 + i);
      tick();
    end
    check("full_level", 32'(fifo_level), 32'd4);
    check("full_drop", 32'(drop_count), 32'd2);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d_kind", i), 32'(evt_kind), (i % 2 == 0) ? 32'd1 : 32'd2);
      check($sformatf("drain%0d_ts", i), 32'(evt_timestamp), 32'(i));
      check($sformatf("drain%0d_count", i), 32'(evt_count), 32'(8'h10 + i));
      evt_ready = 1'b1;
      tick();
    end
    check("drain_empty", 32'(evt_valid), 32'd0);
    evt_ready = 1'b0;

    // Full FIFO, event coincides with pop.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      enable_in = (i % 2 == 0);
      count_in = 8'(8'h20 + i);
      tick();
    end
    check("fp_level0", 32'(fifo_level), 32'd4);
    check("fp_drop0", 32'(drop_count), 32'd0);
    enable_in = 1'b1; count_in = 8'h24; evt_ready = 1'b1;
    tick();
    check("fp_level1", 32'(fifo_level), 32'd4);
    check("fp_drop1", 32'(drop_count), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("fp%0d_kind", i), 32'(evt_kind), (i % 2 == 0) ? 32'd1 : 32'd2);
      check($sformatf("fp%0d_ts", i), 32'(evt_timestamp), 32'(i));
      check($sformatf("fp%0d_count", i), 32'(evt_count), 32'(8'h20 + i));
      tick();
    end
    check("fp_empty", 32'(fifo_level), 32'd0);
    evt_ready = 1'b0;

    // Timestamp wrap on the 4-bit instance, then reset mid-queue.
    do_reset(1'b0, 1'b0);
    repeat (15) tick();
    overflow_in = 1'b1; enable_in = 1'b1; count_in = 8'h3C;
    tick();
    enable_in = 1'b0; count_in = 8'h3D;
    tick();
    check("wrap_level", 32'(s_level), 32'd2);
    check("wrap_kind0", 32'(s_kind), 32'd0);
    check("wrap_ts0", 32'(s_timestamp), 32'd15);
    check("wrap_count0", 32'(s_count), 32'h3C);
    check("wrap_drop", 32'(s_drop), 32'd1);
    evt_ready = 1'b1;
    tick();
    check("wrap_kind1", 32'(s_kind), 32'd2);
    check("wrap_ts1", 32'(s_timestamp), 32'd0);
    check("wrap_count1", 32'(s_count), 32'h3D);
    check("wrap_level1", 32'(s_level), 32'd1);
    evt_ready = 1'b0;
    rst = 1'b1;
    tick();
    check("mrst_level", 32'(s_level), 32'd0);
    check("mrst_drop", 32'(s_drop), 32'd0);
    check("mrst_valid", 32'(s_valid), 32'd0);
    check("mrst_level_w", 32'(fifo_level), 32'd0);
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
